// File: rtl/ddr4_axi_ar_cmd_gen.sv
// AXI read-address stage: accepts one AR burst at a time and splits it into
// memory-controller read commands. It also pushes per-command transaction info
// (ID, last, BL8 half-ignore flags) into the read-data channel's FIFO.
//
// state | meaning
// IDLE  | arready high, waiting for an AR burst
// CMD   | issuing the burst's commands, one per handshake
module ddr4_axi_ar_cmd_gen #(
  parameter int C_ID_WIDTH       = 4,
  parameter int C_DATA_WIDTH     = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_MC_BURST_LEN   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [C_ID_WIDTH-1:0]       arid,
  input  logic [C_AXI_ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]                  arlen,
  input  logic [2:0]                  arsize,
  input  logic [1:0]                  arburst,
  input  logic                        arvalid,
  output logic                        arready,
  output logic                        cmd_en,
  output logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic                        cmd_rdy,
  output logic                        r_push,
  output logic [C_ID_WIDTH-1:0]       r_arid,
  output logic                        r_rlast,
  output logic                        r_ignore_begin,
  output logic                        r_ignore_end,
  input  logic                        r_data_rdy
);

  localparam int AW         = C_AXI_ADDR_WIDTH;
  localparam int BEAT_BYTES = C_DATA_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int CMD_BYTES  = BEAT_BYTES * C_MC_BURST_LEN;
  localparam bit BL2        = (C_MC_BURST_LEN == 2);
  localparam logic [AW-1:0] BEAT_MASK = AW'(BEAT_BYTES - 1);
  localparam logic [AW-1:0] CMD_MASK  = AW'(CMD_BYTES - 1);
  localparam logic [AW-1:0] CMD_INC   = AW'(CMD_BYTES);

  typedef enum logic {IDLE, CMD} state_t;

  state_t          state_q, state_d;
  logic [C_ID_WIDTH-1:0] id_q;
  logic [AW-1:0]   addr_q, wmask_q, addr_next, first_addr, wmask_in;
  logic [8:0]      cnt_q, count_in;
  logic [9:0]      incr_sum;
  logic            is_wrap_q, is_wrap_in, ie_last_q, ie_last_in;
  logic            b0_odd, ib_first_in, ie_first_in;
  logic [1:0]      flags_prev_q;
  logic            flags_stable, ar_fire, push;
  logic [2:0]      unused_arsize;

  // arsize has no effect: every beat is treated as full data width.
  assign unused_arsize = arsize;

  assign ar_fire      = arvalid & arready;
  assign push         = cmd_en & cmd_rdy;
  assign flags_stable = ({r_ignore_begin, r_ignore_end} == flags_prev_q);
  assign b0_odd       = araddr[BEAT_SHIFT];
  assign is_wrap_in   = (arburst == 2'b10);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    cmd_en  = 1'b0;
    case (state_q)
      IDLE: begin
        arready = ~reset;
        if (arvalid && !reset) state_d = CMD;
      end
      CMD: begin
        cmd_en = r_data_rdy & flags_stable;
        if (cmd_en && cmd_rdy && cnt_q == 9'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst decode at AR acceptance: command count, first address, wrap window, flags.
  always_comb begin
    first_addr = araddr & ~CMD_MASK;
    // WRAP lengths are 2^n-1, so (arlen+1)*BEAT_BYTES-1 is arlen*BEAT_BYTES | BEAT_MASK.
    wmask_in   = (AW'(arlen) << BEAT_SHIFT) | BEAT_MASK;
    incr_sum   = 10'(arlen) + 10'(b0_odd) + 10'd2;
    count_in   = 9'(arlen) + 9'd1;
    ie_last_in = 1'b0;
    if (BL2) begin
      if (is_wrap_in) begin
        count_in   = ((9'(arlen) + 9'd1) >> 1) + 9'(b0_odd);
        ie_last_in = b0_odd;
      end else begin
        count_in   = incr_sum[9:1];
        ie_last_in = ~(b0_odd ^ arlen[0]);
      end
    end
    ib_first_in = BL2 & b0_odd;
    ie_first_in = (count_in == 9'd1) & ie_last_in;
  end

  // Next command address: linear for INCR, modulo the aligned window for WRAP.
  always_comb begin
    if (is_wrap_q) addr_next = (addr_q & ~wmask_q) | ((addr_q + CMD_INC) & wmask_q);
    else           addr_next = addr_q + CMD_INC;
  end

  // Burst context and pending-command flags; flags clear after the final command
  // so the next burst starts from a zero flag history.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q           <= '0;
      addr_q         <= '0;
      wmask_q        <= '0;
      is_wrap_q      <= 1'b0;
      cnt_q          <= '0;
      ie_last_q      <= 1'b0;
      r_ignore_begin <= 1'b0;
      r_ignore_end   <= 1'b0;
    end else if (ar_fire) begin
      id_q           <= arid;
      addr_q         <= first_addr;
      wmask_q        <= wmask_in;
      is_wrap_q      <= is_wrap_in;
      cnt_q          <= count_in;
      ie_last_q      <= ie_last_in;
      r_ignore_begin <= ib_first_in;
      r_ignore_end   <= ie_first_in;
    end else if (push) begin
      cnt_q          <= cnt_q - 9'd1;
      addr_q         <= addr_next;
      r_ignore_begin <= 1'b0;
      r_ignore_end   <= (cnt_q == 9'd2) & ie_last_q;
    end
  end

  // One-cycle flag history; a command may only issue once its flags have been
  // visible downstream for a full cycle.
  always_ff @(posedge clk) begin
    if (reset) flags_prev_q <= 2'b00;
    else       flags_prev_q <= {r_ignore_begin, r_ignore_end};
  end

  assign cmd_addr = addr_q;
  assign r_arid   = id_q;
  assign r_rlast  = (state_q == CMD) & (cnt_q == 9'd1);
  assign r_push   = push;

endmodule

// File: tb/tb_ddr4_axi_ar_cmd_gen.sv
// Directed bench: one BL8 (2:1) instance and one BL4 instance share the AR
// inputs; each vector selects which instance's command stream is checked.
module tb_ddr4_axi_ar_cmd_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, cmd_rdy, r_data_rdy;

  logic        arready2, cmd_en2, r_push2, r_rlast2, rib2, rie2;
  logic [31:0] cmd_addr2;
  logic [3:0]  r_arid2;
  logic        arready1, cmd_en1, r_push1, r_rlast1, rib1, rie1;
  logic [31:0] cmd_addr1;
  logic [3:0]  r_arid1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr4_axi_ar_cmd_gen #(.C_ID_WIDTH(4), .C_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(32),
                        .C_MC_BURST_LEN(2)) u_dut_bl2 (
    .clk(clk), .reset(reset), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready2),
    .cmd_en(cmd_en2), .cmd_addr(cmd_addr2), .cmd_rdy(cmd_rdy), .r_push(r_push2),
    .r_arid(r_arid2), .r_rlast(r_rlast2), .r_ignore_begin(rib2), .r_ignore_end(rie2),
    .r_data_rdy(r_data_rdy));

  ddr4_axi_ar_cmd_gen #(.C_ID_WIDTH(4), .C_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(32),
                        .C_MC_BURST_LEN(1)) u_dut_bl1 (
    .clk(clk), .reset(reset), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready1),
    .cmd_en(cmd_en1), .cmd_addr(cmd_addr1), .cmd_rdy(cmd_rdy), .r_push(r_push1),
    .r_arid(r_arid1), .r_rlast(r_rlast1), .r_ignore_begin(rib1), .r_ignore_end(rie1),
    .r_data_rdy(r_data_rdy));

  typedef struct packed {
    logic        bl1;
    logic [1:0]  burst;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [4:0]  first;
    logic [2:0]  n;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        ib;
    logic        ie;
    logic        last;
    logic [3:0]  cyc;
  } cmd_t;

  vec_t vecs[10];
  cmd_t cmds[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(arready1 && arready2) && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (!(arready1 && arready2)) check("idle_timeout", 32'(arready2), 32'd1);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [1:0] burst,
                         input logic [31:0] addr, input logic [7:0] len);
    wait_idle();
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    @(posedge clk);
    #1 arvalid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int got;
    logic [3:0] id;
    logic push, ib, ie, last;
    logic [31:0] addr;
    logic [3:0] rid;
    v = vecs[i];
    got = 0;
    id = 4'(i + 3);
    send_ar(id, v.burst, v.addr, v.len);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      push = v.bl1 ? r_push1 : r_push2;
      ib   = v.bl1 ? rib1 : rib2;
      ie   = v.bl1 ? rie1 : rie2;
      last = v.bl1 ? r_rlast1 : r_rlast2;
      addr = v.bl1 ? cmd_addr1 : cmd_addr2;
      rid  = v.bl1 ? r_arid1 : r_arid2;
      if (k == 1) check($sformatf("v%0d_ib_cycle1", i), 32'(ib), 32'(cmds[v.first].ib));
      if (push) begin
        if (got < int'(v.n)) begin
          cmd_t c;
          c = cmds[int'(v.first) + got];
          check($sformatf("v%0d_c%0d_addr", i, got), addr, c.addr);
          check($sformatf("v%0d_c%0d_ib", i, got), 32'(ib), 32'(c.ib));
          check($sformatf("v%0d_c%0d_ie", i, got), 32'(ie), 32'(c.ie));
          check($sformatf("v%0d_c%0d_rlast", i, got), 32'(last), 32'(c.last));
          check($sformatf("v%0d_c%0d_arid", i, got), 32'(rid), 32'(id));
          check($sformatf("v%0d_c%0d_cycle", i, got), 32'(k), 32'(c.cyc));
        end
        got++;
      end
    end
    check($sformatf("v%0d_push_count", i), 32'(got), 32'(v.n));
  endtask

  initial begin
    // {bl1, burst, addr, len, first cmd index, command count}
    vecs[0] = '{1'b0, 2'b01, 32'h100, 8'd3, 5'd0,  3'd2};
    vecs[1] = '{1'b0, 2'b01, 32'h104, 8'd0, 5'd2,  3'd1};
    vecs[2] = '{1'b0, 2'b01, 32'h104, 8'd1, 5'd3,  3'd2};
    vecs[3] = '{1'b0, 2'b10, 32'h10C, 8'd3, 5'd5,  3'd3};
    vecs[4] = '{1'b1, 2'b10, 32'h10C, 8'd3, 5'd8,  3'd4};
    vecs[5] = '{1'b0, 2'b01, 32'h108, 8'd2, 5'd12, 3'd2};
    vecs[6] = '{1'b1, 2'b01, 32'h200, 8'd2, 5'd14, 3'd3};
    vecs[7] = '{1'b0, 2'b10, 32'h100, 8'd3, 5'd17, 3'd2};
    vecs[8] = '{1'b0, 2'b10, 32'h104, 8'd1, 5'd19, 3'd2};
    vecs[9] = '{1'b0, 2'b11, 32'h1FC, 8'd1, 5'd21, 3'd2};
    // {addr, ignore_begin, ignore_end, rlast, cycle after AR accept}
    cmds[0]  = '{32'h100, 1'b0, 1'b0, 1'b0, 4'd1};
    cmds[1]  = '{32'h108, 1'b0, 1'b0, 1'b1, 4'd2};
    cmds[2]  = '{32'h100, 1'b1, 1'b0, 1'b1, 4'd2};
    cmds[3]  = '{32'h100, 1'b1, 1'b0, 1'b0, 4'd2};
    cmds[4]  = '{32'h108, 1'b0, 1'b1, 1'b1, 4'd4};
    cmds[5]  = '{32'h108, 1'b1, 1'b0, 1'b0, 4'd2};
    cmds[6]  = '{32'h100, 1'b0, 1'b0, 1'b0, 4'd4};
    cmds[7]  = '{32'h108, 1'b0, 1'b1, 1'b1, 4'd6};
    cmds[8]  = '{32'h10C, 1'b0, 1'b0, 1'b0, 4'd1};
    cmds[9]  = '{32'h100, 1'b0, 1'b0, 1'b0, 4'd2};
    cmds[10] = '{32'h104, 1'b0, 1'b0, 1'b0, 4'd3};
    cmds[11] = '{32'h108, 1'b0, 1'b0, 1'b1, 4'd4};
    cmds[12] = '{32'h108, 1'b0, 1'b0, 1'b0, 4'd1};
    cmds[13] = '{32'h110, 1'b0, 1'b1, 1'b1, 4'd3};
    cmds[14] = '{32'h200, 1'b0, 1'b0, 1'b0, 4'd1};
    cmds[15] = '{32'h204, 1'b0, 1'b0, 1'b0, 4'd2};
    cmds[16] = '{32'h208, 1'b0, 1'b0, 1'b1, 4'd3};
    cmds[17] = '{32'h100, 1'b0, 1'b0, 1'b0, 4'd1};
    cmds[18] = '{32'h108, 1'b0, 1'b0, 1'b1, 4'd2};
    cmds[19] = '{32'h100, 1'b1, 1'b0, 1'b0, 4'd2};
    cmds[20] = '{32'h100, 1'b0, 1'b1, 1'b1, 4'd4};
    cmds[21] = '{32'h1F8, 1'b1, 1'b0, 1'b0, 4'd2};
    cmds[22] = '{32'h200, 1'b0, 1'b1, 1'b1, 4'd4};

    reset = 1'b1; arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b0; cmd_rdy = 1'b1; r_data_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_arready", 32'(arready2), 32'd0);
    check("rst_cmd_en", 32'(cmd_en2), 32'd0);
    check("rst_cmd_addr", cmd_addr2, 32'd0);
    check("rst_flags", 32'({rib2, rie2, r_rlast2, r_push2}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_arready", 32'({arready2, arready1}), 32'd3);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Backpressure: r_data_rdy low blocks, then cmd_rdy low stalls with stable outputs.
    r_data_rdy = 1'b0;
    send_ar(4'hA, 2'b01, 32'h100, 8'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_rdy_cmd_en", 32'({cmd_en2, r_push2}), 32'd0);
    end
    r_data_rdy = 1'b1; cmd_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_cmd_en", 32'(cmd_en2), 32'd1);
      check("stall_addr", cmd_addr2, 32'h100);
      check("stall_flags_push", 32'({rib2, rie2, r_push2}), 32'd0);
    end
    @(negedge clk);
    cmd_rdy = 1'b1;
    #1;
    check("stall_release_push", 32'(r_push2), 32'd1);
    check("stall_release_addr", cmd_addr2, 32'h100);
    @(negedge clk);
    check("stall_second_push", 32'({r_push2, r_rlast2}), 32'd3);
    check("stall_second_addr", cmd_addr2, 32'h108);
    @(negedge clk);
    check("stall_done_cmd_en", 32'(cmd_en2), 32'd0);

    // Reset in the middle of a long INCR burst.
    send_ar(4'h5, 2'b01, 32'h0, 8'd255);
    repeat (4) @(negedge clk);
    check("midrst_busy", 32'(r_push2), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cmd_en", 32'({cmd_en2, r_push2, cmd_en1}), 32'd0);
    check("midrst_addr", cmd_addr2, 32'd0);
    check("midrst_fields", 32'({r_arid2, r_rlast2, rib2, rie2}), 32'd0);
    check("midrst_arready", 32'(arready2), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_arready_after", 32'(arready2), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_push", 32'({r_push2, r_push1}), 32'd0);
    end
    run_vec(0);
    run_vec(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
